// File: rtl/serv_dbg_pkg.sv
// Shared constants, size helpers and FSM encoding for the debug register-file shadow.
package serv_dbg_pkg;

  localparam int unsigned DBG_REGNO_W  = 6;
  localparam int unsigned RF_WIDTH_DEF = 8;
  localparam int unsigned CSR_REGS_DEF = 4;

  // NREGS, CHUNKS and CW for a given configuration.
  function automatic int unsigned nregs(input int unsigned csr_regs);
    return 32 + csr_regs;
  endfunction

  function automatic int unsigned chunks(input int unsigned rf_width);
    return 32 / rf_width;
  endfunction

  function automatic int unsigned chunk_w(input int unsigned rf_width);
    return $clog2(32 / rf_width);
  endfunction

  typedef enum logic [1:0] {IDLE, CHECK, WAIT, RESP} dbg_state_e;

endpackage

// File: rtl/serv_dbg_shadow_mem.sv
// NREGS x 32 shadow flop array: per-chunk snoop writes, registered read with
// same-cycle write forwarding.
module serv_dbg_shadow_mem import serv_dbg_pkg::*; #(
  parameter int unsigned RF_WIDTH = RF_WIDTH_DEF,
  parameter int unsigned NREGS    = 36,
  parameter int unsigned CWI      = 2
) (
  input  logic                   clk,
  input  logic                   i_rst_n,
  input  logic                   i_we,
  input  logic [DBG_REGNO_W-1:0] i_wreg,
  input  logic [CWI-1:0]         i_wchunk,
  input  logic [RF_WIDTH-1:0]    i_wdata,
  input  logic                   i_re,
  input  logic [DBG_REGNO_W-1:0] i_raddr,
  output logic [31:0]            o_rdata
);

  localparam int unsigned RW = DBG_REGNO_W + 1;
  localparam logic [RW-1:0] NREGS_W = RW'(NREGS);

  logic [31:0] r_mem [NREGS];
  logic [31:0] r_rdata;
  logic [31:0] w_rd_fwd;
  logic        w_wvalid;

  // x0 is hardwired to zero; addresses past the CSR slots are dropped.
  assign w_wvalid = i_we && (i_wreg != '0) && ({1'b0, i_wreg} < NREGS_W);

  always_comb begin
    w_rd_fwd = '0;
    if ({1'b0, i_raddr} < NREGS_W) begin
      w_rd_fwd = r_mem[i_raddr];
      if (w_wvalid && (i_wreg == i_raddr)) begin
        w_rd_fwd[32'(i_wchunk) * RF_WIDTH +: RF_WIDTH] = i_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_mem   <= '{default: '0};
      r_rdata <= '0;
    end else begin
      if (w_wvalid) begin
        r_mem[i_wreg][32'(i_wchunk) * RF_WIDTH +: RF_WIDTH] <= i_wdata;
      end
      if (i_re) begin
        r_rdata <= w_rd_fwd;
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/serv_dbg_rf_shadow.sv
// Snoops RF RAM writes into a 32-bit shadow and serves debug reads, holding
// off a read while its register is only partly written.
module serv_dbg_rf_shadow import serv_dbg_pkg::*; #(
  parameter int unsigned RF_WIDTH = RF_WIDTH_DEF,
  parameter int unsigned CSR_REGS = CSR_REGS_DEF,
  parameter int unsigned RF_L2D   = $clog2(nregs(CSR_REGS) * 32 / RF_WIDTH)
) (
  input  logic                   clk,
  input  logic                   i_rst_n,
  input  logic [RF_L2D-1:0]      i_rf_waddr,
  input  logic [RF_WIDTH-1:0]    i_rf_wdata,
  input  logic                   i_rf_wen,
  input  logic                   i_dbg_req,
  input  logic [DBG_REGNO_W-1:0] i_dbg_regno,
  output logic                   o_dbg_ack,
  output logic [31:0]            o_dbg_rdata,
  output logic                   o_dbg_err,
  output logic                   o_seq_err
);

  localparam int unsigned NREGS  = nregs(CSR_REGS);
  localparam int unsigned CHUNKS = chunks(RF_WIDTH);
  localparam int unsigned CW     = chunk_w(RF_WIDTH);
  localparam int unsigned CWI    = (CW == 0) ? 1 : CW;
  localparam int unsigned RW     = DBG_REGNO_W + 1;
  localparam logic [RW-1:0]  NREGS_W    = RW'(NREGS);
  localparam logic [CWI-1:0] LAST_CHUNK = CWI'(CHUNKS - 1);

  dbg_state_e             r_state, w_state_d;
  logic [DBG_REGNO_W-1:0] r_regno, w_regno_d;
  logic                   r_err, w_err_d;
  logic                   r_busy, w_busy_d;
  logic [DBG_REGNO_W-1:0] r_busy_reg, w_busy_reg_d;
  logic [CWI-1:0]         r_exp_chunk, w_exp_d;
  logic                   r_seq_err, w_seq_err_d;

  logic [DBG_REGNO_W-1:0] w_wreg;
  logic [CWI-1:0]         w_wchunk;
  logic                   w_re, w_oob, w_hold;

  assign w_wreg   = DBG_REGNO_W'(i_rf_waddr >> CW);
  assign w_wchunk = (CW == 0) ? '0 : CWI'(i_rf_waddr);

  always_comb begin
    w_busy_d     = r_busy;
    w_busy_reg_d = r_busy_reg;
    w_exp_d      = r_exp_chunk;
    w_seq_err_d  = r_seq_err;
    if (i_rf_wen) begin
      if (w_wchunk == LAST_CHUNK) begin
        w_busy_d = 1'b0;
      end else if (w_wchunk == '0) begin
        w_busy_d     = 1'b1;
        w_busy_reg_d = w_wreg;
      end
      if (w_wchunk != r_exp_chunk) w_seq_err_d = 1'b1;
      w_exp_d = (w_wchunk == LAST_CHUNK) ? '0 : w_wchunk + CWI'(1);
    end
  end

  // Conflict is judged on post-write tracking state, so a same-cycle chunk 0
  // stalls the read and a same-cycle final chunk (forwarded) releases it.
  assign w_oob  = ({1'b0, r_regno} >= NREGS_W);
  assign w_hold = w_busy_d && (w_busy_reg_d == r_regno);

  always_comb begin
    w_state_d = r_state;
    w_regno_d = r_regno;
    w_err_d   = r_err;
    w_re      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_dbg_req) begin
          w_regno_d = i_dbg_regno;
          w_state_d = CHECK;
        end
      end
      CHECK, WAIT: begin
        if (w_oob) begin
          w_state_d = RESP;
          w_err_d   = 1'b1;
          w_re      = 1'b1;
        end else if (w_hold) begin
          w_state_d = WAIT;
        end else begin
          w_state_d = RESP;
          w_err_d   = 1'b0;
          w_re      = 1'b1;
        end
      end
      RESP:    w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_regno     <= '0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_busy_reg  <= '0;
      r_exp_chunk <= '0;
      r_seq_err   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_regno     <= w_regno_d;
      r_err       <= w_err_d;
      r_busy      <= w_busy_d;
      r_busy_reg  <= w_busy_reg_d;
      r_exp_chunk <= w_exp_d;
      r_seq_err   <= w_seq_err_d;
    end
  end

  serv_dbg_shadow_mem #(
    .RF_WIDTH (RF_WIDTH),
    .NREGS    (NREGS),
    .CWI      (CWI)
  ) u_mem (
    .clk      (clk),
    .i_rst_n  (i_rst_n),
    .i_we     (i_rf_wen),
    .i_wreg   (w_wreg),
    .i_wchunk (w_wchunk),
    .i_wdata  (i_rf_wdata),
    .i_re     (w_re),
    .i_raddr  (r_regno),
    .o_rdata  (o_dbg_rdata)
  );

  assign o_dbg_ack = (r_state == RESP);
  assign o_dbg_err = r_err;
  assign o_seq_err = r_seq_err;

endmodule
